load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the byte-addressable data memory port. Accepts one load or store request at a time from the execute stage, drives the memory's combinational-read / clocked-write interface, and returns a single-cycle response. Implements RV32I LB/LH/LW/LBU/LHU/SB/SH/SW. Sub-word stores use read-modify-write, because the memory always writes four consecutive bytes at addr..addr+3.

## Interface
Parameters:
- WIDTH, 32, data and address width; fixed at 32 for RV32I.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high. One clock domain.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  WIDTH  byte address.
- req_wdata  in  WIDTH  store data; low bytes are used for B and H.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  WIDTH  extended load result; 0 for stores and errors.
- rsp_err  out  1  illegal funct3, or misaligned access when trapping is enabled.
- mem_addr  out  WIDTH  memory byte address.
- mem_wdata  out  WIDTH  memory write word, little-endian.
- mem_we  out  1  memory write enable.
- mem_rdata  in  WIDTH  memory read word, combinational from mem_addr.

## Operation
- Handshake: a request is accepted on a clk edge where req_valid && req_ready. All request fields are registered at acceptance. There is no response backpressure.
- FSM states: IDLE, LD, RD, WR, RESP.
- IDLE transitions on accept:
  - illegal request → RESP with rsp_err set.
  - load → LD.
  - SW → WR.
  - SB/SH → RD.
- LD: mem_addr = captured addr. rsp_rdata is registered from mem_rdata at the end of the cycle:
  - B: sign-extend [7:0].
  - BU: zero-extend [7:0].
  - H: sign-extend [15:0].
  - HU: zero-extend [15:0].
  - W: full word.
  - Next state: RESP.
- RD: mem_addr = addr. mem_rdata is captured into the merge register. Next state: WR.
- WR: mem_addr = addr and mem_we = 1 for exactly one cycle. mem_wdata is:
  - SW: req_wdata.
  - SH: {old[31:16], wdata[15:0]}.
  - SB: {old[31:8], wdata[7:0]}.
  - Next state: RESP.
- RESP: rsp_valid = 1 for one cycle, then IDLE.
- Illegal funct3:
  - loads: 011, 110, 111.
  - stores: anything other than 000/001/010.
  - Response: rsp_err = 1, rsp_rdata = 0, no memory write.
- In IDLE, RESP and LD, mem_we = 0. mem_addr and mem_wdata hold their last values.

## Timing
- Latency from the accept edge to rsp_valid:
  - load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - error: 1 cycle.
- Throughput: one request per 3 cycles for loads and SW; one per 4 cycles for SB/SH.
- Reset values: state = IDLE, req_ready = 1 after reset deassertion, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Reset asserted mid-operation (including in WR) forces mem_we low immediately, asynchronously. The in-flight request is dropped with no response.
- req_valid arriving in RESP is not accepted until the following IDLE cycle.
- Addresses are passed through unchanged. Wrap-around beyond the memory depth is the memory's concern.

## Configuration
- MISALIGN_TRAP_EN defined: misaligned H/HU (addr[0] = 1) and W (addr[1:0] ≠ 0) requests take IDLE → RESP with rsp_err = 1. There is no memory access and no write.
- MISALIGN_TRAP_EN undefined: every legal funct3 proceeds at the exact byte address. rsp_err is set only for illegal funct3.

## Structure
- lsu_pkg holds the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum typedef lsu_state_t.
- One combinational sub-module, lsu_align, is natural: load extension plus store byte-lane merge. The FSM and registers stay in load_store_unit.

## Test plan
- Memory bytes 0x10..0x13 = 80 7F 01 FF:
  - LB 0x10 → rsp_rdata 0xFFFFFF80.
  - LBU 0x10 → 0x00000080.
  - LW 0x10 → 0xFF017F80.
- SB addr 0x20, wdata 0xAAAAAA5C, old word 0x11223344 → one mem_we pulse with mem_wdata 0x1122335C. rsp_valid arrives 3 cycles after accept.
- SH 0x24 with wdata 0x0000BEEF over old word 0xFFFFFFFF, then LH 0x24 → 0xFFFFBEEF. A following LHU 0x24 → 0x0000BEEF.
- funct3 011 load and funct3 100 store → rsp_err = 1 after 1 cycle, mem_we never asserted, rsp_rdata = 0.
- LW 0x21:
  - with MISALIGN_TRAP_EN: rsp_err = 1, no access.
  - without it: returns bytes 0x21..0x24, little-endian.
- Assert rst during WR of an SW → mem_we drops immediately, no rsp_valid, req_ready = 1 after release, and the next LW returns the unmodified word.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and request decode helpers
//
// Purpose: definitions shared by load_store_unit and lsu_align.
//   F3_*         RV32I load/store funct3 encodings
//   lsu_state_t  load_store_unit FSM state
//   f3_illegal   1 when funct3 is not a legal load/store width
//   misaligned   1 when the address is not naturally aligned for the width
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LD   = 3'd1,
      RD   = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } lsu_state_t;

   // Stores have no unsigned variants, so only B/H/W are legal for them.
   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      if (store)
         return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
      else
         return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_H, F3_HU: return a[0];
         F3_W:        return (a != 2'b00);
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load extension and store byte-lane merge
//
// Purpose: purely combinational data alignment for load_store_unit.
// Ports:
//   funct3      in   access width / signedness
//   rdata       in   word read from memory (load data or old word for merge)
//   wdata       in   store data from the request (low bytes used for B/H)
//   load_data   out  sign/zero-extended load result
//   merge_data  out  write word: new low byte(s) over the old upper bytes
module lsu_align
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] rdata,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] merge_data
);

   always_comb begin
      load_data = rdata;
      case (funct3)
         F3_B:    load_data = {{(WIDTH-8){rdata[7]}}, rdata[7:0]};
         F3_BU:   load_data = {{(WIDTH-8){1'b0}}, rdata[7:0]};
         F3_H:    load_data = {{(WIDTH-16){rdata[15]}}, rdata[15:0]};
         F3_HU:   load_data = {{(WIDTH-16){1'b0}}, rdata[15:0]};
         default: load_data = rdata;
      endcase
   end

   // The memory always writes a full word at addr, so sub-word stores keep the
   // bytes above the written lane(s) from the word read just before.
   always_comb begin
      merge_data = wdata;
      case (funct3)
         F3_B:    merge_data = {rdata[WIDTH-1:8], wdata[7:0]};
         F3_H:    merge_data = {rdata[WIDTH-1:16], wdata[15:0]};
         default: merge_data = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator for a byte-addressed data memory
//
// Purpose: accepts one load/store at a time, drives a combinational-read /
// clocked-write memory port and returns a one-cycle response. Sub-word stores
// are done as read-modify-write.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned H/HU/W
// accesses with rsp_err instead of performing them at the exact byte address.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_store/req_funct3             operation and width
//   req_addr/req_wdata               byte address and store data
//   rsp_valid/rsp_rdata/rsp_err      one-cycle response
//   mem_addr/mem_wdata/mem_we        memory address, write word, write enable
//   mem_rdata                        memory read word (combinational)
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_store,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             rsp_valid,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_we,
   input  logic [WIDTH-1:0] mem_rdata
);

   lsu_state_t       state, state_nx;
   logic [2:0]       f3_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] merge_data;
   logic             accept;
   logic             req_err;

   assign accept = req_valid && req_ready;

`ifdef MISALIGN_TRAP_EN
   assign req_err = f3_illegal(req_store, req_funct3) ||
                    misaligned(req_funct3, req_addr[1:0]);
`else
   assign req_err = f3_illegal(req_store, req_funct3);
`endif

   lsu_align #(.WIDTH(WIDTH)) u_align (
      .funct3     (f3_q),
      .rdata      (mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)
                  state_nx = RESP;
               else if (!req_store)
                  state_nx = LD;
               else if (req_funct3 == F3_W)
                  state_nx = WR;
               else
                  state_nx = RD;
            end
         end
         LD:      state_nx = RESP;
         RD:      state_nx = WR;
         WR:      state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs decoded from state; mem_we falls with the async state reset.
   always_comb begin
      req_ready = (state == IDLE);
      rsp_valid = (state == RESP);
      mem_we    = (state == WR);
   end

   // Datapath registers. mem_addr doubles as the captured request address and
   // mem_wdata as the merge register, so both hold between requests.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f3_q      <= 3'b000;
         wdata_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  f3_q      <= req_funct3;
                  wdata_q   <= req_wdata;
                  rsp_rdata <= '0;
                  rsp_err   <= req_err;
                  if (!req_err) begin
                     mem_addr <= req_addr;
                     if (req_store && (req_funct3 == F3_W))
                        mem_wdata <= req_wdata;
                  end
               end
            end
            LD:      rsp_rdata <= load_data;
            RD:      mem_wdata <= merge_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking scoreboard bench for load_store_unit
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata)
   );

   // 256-byte memory model: combinational read, clocked 4-byte write.
   logic [7:0] mem [0:255];
   logic [7:0] ra;
   assign ra = mem_addr[7:0];
   assign mem_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

   always @(posedge clk) begin
      if (mem_we)
         for (int i = 0; i < 4; i++)
            mem[ra + 8'(i)] <= mem_wdata[8*i +: 8];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
      string       tag;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          passed = 0;
   int          we_cnt = 0;
   logic [31:0] we_data = '0;
   int          last_wait;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt++;
         we_data = mem_wdata;
      end
      if (!rst && rsp_valid) begin
         if (sbq.size() == 0)
            chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
         else begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({e.tag, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
            chk({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
         end
      end
   end

   // Drive one request, wait (bounded) for acceptance, then push the expectation.
   // lat = cycles from accept edge to rsp_valid.
   task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input string tag);
      exp_t e;
      int   w;
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      w = 0;
      while (!req_ready && w < 8) begin
         @(negedge clk);
         w++;
      end
      last_wait = w;
      @(posedge clk);
      #1;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.due   = cyc + lat - 1;
      e.tag   = tag;
      sbq.push_back(e);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int w0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hFF017F80;
      {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'h11223344;
      {mem[8'h27], mem[8'h26], mem[8'h25], mem[8'h24]} = 32'hFFFFFFFF;

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

      // Loads over bytes 80 7F 01 FF
      send(1'b0, F3_B,  32'h10, 0, 32'hFFFFFF80, 1'b0, 2, "lb_10");  drain();
      send(1'b0, F3_BU, 32'h10, 0, 32'h00000080, 1'b0, 2, "lbu_10"); drain();
      send(1'b0, F3_W,  32'h10, 0, 32'hFF017F80, 1'b0, 2, "lw_10");  drain();
      send(1'b0, F3_H,  32'h10, 0, 32'h00007F80, 1'b0, 2, "lh_10");  drain();
      send(1'b0, F3_H,  32'h12, 0, 32'hFFFFFF01, 1'b0, 2, "lh_12");  drain();
      send(1'b0, F3_HU, 32'h12, 0, 32'h0000FF01, 1'b0, 2, "lhu_12"); drain();

      // SB read-modify-write
      w0 = we_cnt;
      send(1'b1, F3_B, 32'h20, 32'hAAAAAA5C, 32'h0, 1'b0, 3, "sb_20"); drain();
      chk("sb_we_pulses", 32'(we_cnt - w0), 32'd1);
      chk("sb_mem_wdata", we_data, 32'h1122335C);
      send(1'b0, F3_W, 32'h20, 0, 32'h1122335C, 1'b0, 2, "lw_20_after_sb"); drain();

      // SH over all-ones word, then signed and unsigned reads
      send(1'b1, F3_H,  32'h24, 32'h0000BEEF, 32'h0, 1'b0, 3, "sh_24"); drain();
      send(1'b0, F3_H,  32'h24, 0, 32'hFFFFBEEF, 1'b0, 2, "lh_24");  drain();
      send(1'b0, F3_HU, 32'h24, 0, 32'h0000BEEF, 1'b0, 2, "lhu_24"); drain();

      // Illegal funct3: immediate error, no write
      w0 = we_cnt;
      send(1'b0, 3'b011, 32'h10, 0, 32'h0, 1'b1, 1, "ld_f3_011"); drain();
      send(1'b1, 3'b100, 32'h28, 32'h12345678, 32'h0, 1'b1, 1, "st_f3_100"); drain();
      chk("illegal_no_we", 32'(we_cnt - w0), 32'd0);

      // SW then read back
      w0 = we_cnt;
      send(1'b1, F3_W, 32'h28, 32'hCAFEF00D, 32'h0, 1'b0, 2, "sw_28"); drain();
      chk("sw_we_pulses", 32'(we_cnt - w0), 32'd1);
      send(1'b0, F3_W, 32'h28, 0, 32'hCAFEF00D, 1'b0, 2, "lw_28"); drain();

      // Misaligned accesses
      w0 = we_cnt;
`ifdef MISALIGN_TRAP_EN
      send(1'b0, F3_W, 32'h21, 0, 32'h0, 1'b1, 1, "lw_21_trap");  drain();
      send(1'b0, F3_H, 32'h25, 0, 32'h0, 1'b1, 1, "lh_25_trap");  drain();
      send(1'b1, F3_H, 32'h25, 32'h1, 32'h0, 1'b1, 1, "sh_25_trap"); drain();
      chk("trap_no_we", 32'(we_cnt - w0), 32'd0);
`else
      send(1'b0, F3_W, 32'h21, 0, 32'hEF112233, 1'b0, 2, "lw_21"); drain();
      send(1'b0, F3_H, 32'h25, 0, 32'hFFFFFFBE, 1'b0, 2, "lh_25"); drain();
      chk("misaligned_load_no_we", 32'(we_cnt - w0), 32'd0);
`endif

      // Back-to-back loads: second is held off through LD and RESP
      send(1'b0, F3_W,  32'h10, 0, 32'hFF017F80, 1'b0, 2, "b2b_first");
      send(1'b0, F3_BU, 32'h13, 0, 32'h000000FF, 1'b0, 2, "b2b_second");
      chk("b2b_ready_wait", 32'(last_wait), 32'd2);
      drain();

      // Reset during WR of an SW: write must be dropped
      @(negedge clk);
      req_valid  = 1'b1;
      req_store  = 1'b1;
      req_funct3 = F3_W;
      req_addr   = 32'h30;
      req_wdata  = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      #2;
      chk("wr_mem_we_high", {31'b0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_in_wr_we_low", {31'b0, mem_we}, 32'd0);
      chk("rst_in_wr_no_rsp", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", {31'b0, req_ready}, 32'd1);
      send(1'b0, F3_W, 32'h30, 0, 32'h00000000, 1'b0, 2, "lw_30_after_rst"); drain();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
